// File: rtl/fx2_slave_fifo_model.sv
// fx2_slave_fifo_model: FX2 slave-FIFO responder (EP2 OUT, EP6 IN)
// with a ready/valid host port to preload EP2 and drain EP6.
module fx2_slave_fifo_model #(
  parameter int DEPTH     = 256,
  parameter int PKT_WORDS = 256
) (
  input  logic        USB_IFCLK,
  input  logic        USB_RST,
  input  logic [1:0]  USB_ADDR,
  input  logic        USB_SLRD,
  input  logic        USB_SLWR,
  input  logic        USB_SLOE,
  input  logic        USB_PKEND,
  inout  wire  [15:0] USB_DATA,
  output logic        USB_FLAGA,
  output logic        USB_FLAGB,
  output logic        USB_FLAGC,
  output logic        USB_FLAGD,
  input  logic [15:0] HOST_WR_DATA,
  input  logic        HOST_WR_VALID,
  output logic        HOST_WR_READY,
  output logic [15:0] HOST_RD_DATA,
  output logic        HOST_RD_LAST,
  output logic        HOST_RD_VALID,
  input  logic        HOST_RD_READY,
  output logic        ERR_UNDERRUN,
  output logic        ERR_OVERRUN,
  output logic        ERR_CONTEN
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] PKT  = CW'(PKT_WORDS);

  logic [15:0] ep2_mem [DEPTH];
  logic [15:0] ep6_mem [DEPTH];
  logic        ep6_lst [DEPTH];

  logic [AW-1:0] o_wr_q, o_wr_d;
  logic [AW-1:0] o_rd_q, o_rd_d;
  logic [CW-1:0] o_cnt_q, o_cnt_d;

  logic [AW-1:0] i_wr_q, i_wr_d;
  logic [AW-1:0] i_cm_q, i_cm_d;
  logic [AW-1:0] i_rd_q, i_rd_d;
  logic [CW-1:0] i_cnt_q, i_cnt_d;
  logic [CW-1:0] i_unc_q, i_unc_d;

  logic err_un_q, err_un_d;
  logic err_ov_q, err_ov_d;
  logic err_ct_q, err_ct_d;

  logic          sel_ep2;
  logic          sel_ep6;
  logic          oe;
  logic          rd_stb;
  logic          rd_ok;
  logic          push;
  logic          wr_stb;
  logic          wr_ok;
  logic          pk_stb;
  logic          pop;
  logic          commit;
  logic [CW-1:0] unc_w;
  logic [CW-1:0] i_ccnt;

  logic          lw_en;
  logic          lw_val;
  logic [AW-1:0] lw_idx;

  // Strobe decode and acceptance, all from pre-edge state
  always_comb begin
    sel_ep2 = (USB_ADDR == 2'b00);
    sel_ep6 = (USB_ADDR == 2'b10);
    oe      = ~USB_SLOE & sel_ep2;
    rd_stb  = ~USB_SLRD & oe;
    rd_ok   = rd_stb & (o_cnt_q != '0);
    push    = HOST_WR_VALID & HOST_WR_READY;
    wr_stb  = ~USB_SLWR & sel_ep6;
    wr_ok   = wr_stb & (i_cnt_q != FULL);
    pk_stb  = ~USB_PKEND & sel_ep6;
    pop     = HOST_RD_VALID & HOST_RD_READY;
    unc_w   = i_unc_q + CW'(wr_ok);
    commit  = (pk_stb & (unc_w != '0))
            | (wr_ok & (unc_w == PKT));
  end

  // One write port for the last-bit array: a write
  // carries its own bit, a bare PKEND tags the newest.
  always_comb begin
    lw_en  = wr_ok | commit;
    lw_val = commit;
    lw_idx = i_wr_q;
    if (!wr_ok) begin
      lw_idx = i_wr_q - AW'(1);
    end
  end

  assign i_ccnt = i_cnt_q - i_unc_q;

  assign USB_FLAGA     = (o_cnt_q != '0);
  assign USB_FLAGC     = (o_cnt_q == '0);
  assign USB_FLAGB     = (i_cnt_q == FULL);
  assign USB_FLAGD     = (i_cnt_q != FULL);
  assign HOST_WR_READY = (o_cnt_q != FULL);
  assign HOST_RD_VALID = (i_ccnt != '0);
  assign HOST_RD_DATA  = HOST_RD_VALID ? ep6_mem[i_rd_q] : '0;
  assign HOST_RD_LAST  = HOST_RD_VALID & ep6_lst[i_rd_q];
  assign ERR_UNDERRUN  = err_un_q;
  assign ERR_OVERRUN   = err_ov_q;
  assign ERR_CONTEN    = err_ct_q;

  assign USB_DATA = oe ? ep2_mem[o_rd_q] : 16'bz;

  always_comb begin
    o_wr_d   = o_wr_q + AW'(push);
    o_rd_d   = o_rd_q + AW'(rd_ok);
    o_cnt_d  = o_cnt_q;
    unique case ({push, rd_ok})
      2'b10:   o_cnt_d = o_cnt_q + CW'(1);
      2'b01:   o_cnt_d = o_cnt_q - CW'(1);
      default: o_cnt_d = o_cnt_q;
    endcase

    i_wr_d   = i_wr_q + AW'(wr_ok);
    i_rd_d   = i_rd_q + AW'(pop);
    i_cm_d   = i_cm_q;
    i_unc_d  = unc_w;
    if (commit) begin
      i_cm_d  = i_wr_d;
      i_unc_d = '0;
    end
    i_cnt_d  = i_cnt_q;
    unique case ({wr_ok, pop})
      2'b10:   i_cnt_d = i_cnt_q + CW'(1);
      2'b01:   i_cnt_d = i_cnt_q - CW'(1);
      default: i_cnt_d = i_cnt_q;
    endcase

    err_un_d = err_un_q | (rd_stb & ~rd_ok);
    err_ov_d = err_ov_q | (wr_stb & ~wr_ok);
    err_ct_d = err_ct_q | (oe & ~USB_SLWR);
  end

  always_ff @(posedge USB_IFCLK) begin
    if (USB_RST) begin
      o_wr_q   <= '0;
      o_rd_q   <= '0;
      o_cnt_q  <= '0;
      i_wr_q   <= '0;
      i_cm_q   <= '0;
      i_rd_q   <= '0;
      i_cnt_q  <= '0;
      i_unc_q  <= '0;
      err_un_q <= 1'b0;
      err_ov_q <= 1'b0;
      err_ct_q <= 1'b0;
    end else begin
      o_wr_q   <= o_wr_d;
      o_rd_q   <= o_rd_d;
      o_cnt_q  <= o_cnt_d;
      i_wr_q   <= i_wr_d;
      i_cm_q   <= i_cm_d;
      i_rd_q   <= i_rd_d;
      i_cnt_q  <= i_cnt_d;
      i_unc_q  <= i_unc_d;
      err_un_q <= err_un_d;
      err_ov_q <= err_ov_d;
      err_ct_q <= err_ct_d;
    end
  end

  // Storage is never cleared; counts alone define what is live
  always_ff @(posedge USB_IFCLK) begin
    if (!USB_RST) begin
      if (push) begin
        ep2_mem[o_wr_q] <= HOST_WR_DATA;
      end
      if (wr_ok) begin
        ep6_mem[i_wr_q] <= USB_DATA;
      end
      if (lw_en) begin
        ep6_lst[lw_idx] <= lw_val;
      end
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// tb_fx2_slave_fifo_model: directed plus random stimulus checked
// against a queue-based model of the two endpoints.
module tb_fx2_slave_fifo_model;

  localparam int DEPTH     = 256;
  localparam int PKT_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        slrd;
  logic        slwr;
  logic        sloe;
  logic        pkend;
  logic [15:0] tb_data;
  logic        tb_oe;
  wire  [15:0] bus;
  logic        flaga;
  logic        flagb;
  logic        flagc;
  logic        flagd;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic        rd_ready;
  logic        e_un;
  logic        e_ov;
  logic        e_ct;

  int npass = 0;
  int ntot  = 0;

  logic [15:0] ep2[$];
  logic [16:0] cq[$];
  logic [16:0] uq[$];
  bit          m_un;
  bit          m_ov;
  bit          m_ct;

  always #5 clk = ~clk;

  assign tb_oe = sloe || (addr != 2'b00);
  assign bus   = tb_oe ? tb_data : 16'bz;

  fx2_slave_fifo_model #(
    .DEPTH    (DEPTH),
    .PKT_WORDS(PKT_WORDS)
  ) dut (
    .USB_IFCLK    (clk),
    .USB_RST      (rst),
    .USB_ADDR     (addr),
    .USB_SLRD     (slrd),
    .USB_SLWR     (slwr),
    .USB_SLOE     (sloe),
    .USB_PKEND    (pkend),
    .USB_DATA     (bus),
    .USB_FLAGA    (flaga),
    .USB_FLAGB    (flagb),
    .USB_FLAGC    (flagc),
    .USB_FLAGD    (flagd),
    .HOST_WR_DATA (wr_data),
    .HOST_WR_VALID(wr_valid),
    .HOST_WR_READY(wr_ready),
    .HOST_RD_DATA (rd_data),
    .HOST_RD_LAST (rd_last),
    .HOST_RD_VALID(rd_valid),
    .HOST_RD_READY(rd_ready),
    .ERR_UNDERRUN (e_un),
    .ERR_OVERRUN  (e_ov),
    .ERR_CONTEN   (e_ct)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  // Endpoint rules applied to the inputs present at this edge
  task automatic model_edge();
    int n2 = ep2.size();
    int nc = cq.size();
    int nu = uq.size();
    bit acc = 0;
    logic [16:0] t;
    if (rst) begin
      ep2.delete();
      cq.delete();
      uq.delete();
      m_un = 0;
      m_ov = 0;
      m_ct = 0;
      return;
    end
    if (!slrd && !sloe && addr == 2'b00) begin
      if (n2 > 0) void'(ep2.pop_front());
      else m_un = 1;
    end
    if (wr_valid && n2 < DEPTH) ep2.push_back(wr_data);
    if (!sloe && !slwr && addr == 2'b00) m_ct = 1;
    if (rd_ready && nc > 0) void'(cq.pop_front());
    if (!slwr && addr == 2'b10) begin
      if (nc + nu < DEPTH) begin
        uq.push_back({1'b0, tb_data});
        acc = 1;
      end else begin
        m_ov = 1;
      end
    end
    if (uq.size() > 0 &&
        ((!pkend && addr == 2'b10) ||
         (acc && uq.size() == PKT_WORDS))) begin
      t = uq[uq.size()-1];
      t[16] = 1'b1;
      uq[uq.size()-1] = t;
      foreach (uq[k]) cq.push_back(uq[k]);
      uq.delete();
    end
  endtask

  task automatic check_all();
    chk("flaga", 32'(flaga), 32'(ep2.size() != 0));
    chk("flagc", 32'(flagc), 32'(ep2.size() == 0));
    chk("flagb", 32'(flagb),
        32'(cq.size() + uq.size() == DEPTH));
    chk("flagd", 32'(flagd),
        32'(cq.size() + uq.size() != DEPTH));
    chk("wr_ready", 32'(wr_ready), 32'(ep2.size() != DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(cq.size() != 0));
    chk("err_un", 32'(e_un), 32'(m_un));
    chk("err_ov", 32'(e_ov), 32'(m_ov));
    chk("err_ct", 32'(e_ct), 32'(m_ct));
    if (!sloe && addr == 2'b00 && ep2.size() != 0)
      chk("bus", 32'(bus), 32'(ep2[0]));
    if (cq.size() != 0) begin
      chk("rd_data", 32'(rd_data), 32'(cq[0][15:0]));
      chk("rd_last", 32'(rd_last), 32'(cq[0][16]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst      = 1'b0;
    addr     = 2'b01;
    slrd     = 1'b1;
    slwr     = 1'b1;
    sloe     = 1'b1;
    pkend    = 1'b1;
    tb_data  = 16'h5A5A;
    wr_data  = 16'h0000;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_flaga", 32'(flaga), 32'(0));
    chk("rst_flagb", 32'(flagb), 32'(0));
    chk("rst_flagc", 32'(flagc), 32'(1));
    chk("rst_flagd", 32'(flagd), 32'(1));
    chk("rst_wr_ready", 32'(wr_ready), 32'(1));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_last", 32'(rd_last), 32'(0));
    chk("rst_bus_free", 32'(bus), 32'(16'h5A5A));

    // EP2 transfer
    wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 16'(i);
      step();
    end
    wr_valid = 1'b0;
    addr = 2'b00;
    sloe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      slrd = 1'b0;
      #1;
      chk("ep2_bus_seq", 32'(bus), 32'(i));
      step();
    end
    slrd = 1'b1;
    chk("ep2_flaga_drop", 32'(flaga), 32'(0));
    chk("ep2_flagc", 32'(flagc), 32'(1));
    chk("ep2_no_underrun", 32'(e_un), 32'(0));

    // EP6 short packet
    idle();
    addr = 2'b10;
    slwr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tb_data = 16'hA0 + 16'(i);
      step();
      chk("ep6_no_valid_early", 32'(rd_valid), 32'(0));
    end
    slwr  = 1'b1;
    pkend = 1'b0;
    step();
    pkend = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("ep6_pop_valid", 32'(rd_valid), 32'(1));
      chk("ep6_pop_data", 32'(rd_data), 32'(16'hA0 + i));
      chk("ep6_pop_last", 32'(rd_last), 32'(i == 4));
      step();
    end
    rd_ready = 1'b0;
    chk("ep6_drained", 32'(rd_valid), 32'(0));

    // EP6 full with auto-commit, then write plus pop at full
    idle();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    addr = 2'b10;
    slwr = 1'b0;
    for (int i = 0; i < 257; i++) begin
      tb_data = 16'h1000 + 16'(i);
      step();
      if (i == 255) begin
        chk("full_flagd", 32'(flagd), 32'(0));
        chk("full_flagb", 32'(flagb), 32'(1));
        chk("full_no_ovr", 32'(e_ov), 32'(0));
        chk("auto_commit", 32'(rd_valid), 32'(1));
      end
    end
    chk("full_overrun", 32'(e_ov), 32'(1));
    chk("full_head", 32'(rd_data), 32'(16'h1000));
    tb_data  = 16'hDEAD;
    rd_ready = 1'b1;
    step();
    chk("wr_pop_flagd", 32'(flagd), 32'(1));
    chk("wr_pop_flagb", 32'(flagb), 32'(0));
    chk("wr_pop_ovr", 32'(e_ov), 32'(1));
    slwr = 1'b1;
    for (int i = 1; i < 256; i++) begin
      chk("full_data", 32'(rd_data), 32'(16'h1000 + i));
      chk("full_last", 32'(rd_last), 32'(i == 255));
      step();
    end
    rd_ready = 1'b0;
    chk("full_drained", 32'(rd_valid), 32'(0));

    // Push and read together with one word in EP2
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 16'h0BEE;
    step();
    wr_data = 16'h0C0D;
    addr = 2'b00;
    sloe = 1'b0;
    slrd = 1'b0;
    step();
    chk("sim_flaga", 32'(flaga), 32'(1));
    chk("sim_bus", 32'(bus), 32'(16'h0C0D));
    wr_valid = 1'b0;
    step();
    chk("sim_empty", 32'(flagc), 32'(1));

    // Empty read, then contention
    step();
    slrd = 1'b1;
    chk("underrun", 32'(e_un), 32'(1));
    chk("underrun_flagc", 32'(flagc), 32'(1));
    wr_valid = 1'b1;
    wr_data  = 16'h7777;
    step();
    wr_valid = 1'b0;
    chk("ptr_kept_bus", 32'(bus), 32'(16'h7777));
    slwr = 1'b0;
    step();
    slwr = 1'b1;
    chk("conten", 32'(e_ct), 32'(1));
    chk("conten_bus", 32'(bus), 32'(16'h7777));
    chk("conten_flagd", 32'(flagd), 32'(1));

    // Reset mid-packet
    idle();
    addr = 2'b10;
    slwr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tb_data = 16'h3300 + 16'(i);
      step();
    end
    slwr = 1'b1;
    rst  = 1'b1;
    step();
    rst   = 1'b0;
    pkend = 1'b0;
    step();
    pkend = 1'b1;
    step();
    chk("midrst_valid", 32'(rd_valid), 32'(0));
    chk("midrst_flagc", 32'(flagc), 32'(1));
    chk("midrst_flagd", 32'(flagd), 32'(1));

    // Random traffic
    idle();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      addr     = 2'($urandom_range(0, 3));
      slrd     = ($urandom_range(0, 1) == 1);
      slwr     = ($urandom_range(0, 3) == 0);
      sloe     = ($urandom_range(0, 1) == 1);
      pkend    = ($urandom_range(0, 15) != 0);
      tb_data  = 16'($urandom);
      wr_data  = 16'($urandom);
      wr_valid = ($urandom_range(0, 1) == 1);
      rd_ready = (i < 1500) ? ($urandom_range(0, 15) == 0)
                            : ($urandom_range(0, 1) == 1);
      step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
